gpio_mmio: RTL and testbench

Memory-mapped GPIO peripheral on the processor data bus. It is the responder end of the GPIO_i/GPIO_o pins that the mips core exposes to the board and bench. Each input bit passes through a 2-flop synchroniser and a per-bit debouncer, and rising edges are captured into a sticky write-1-to-clear register. An output register drives GPIO_o, and an interrupt line is raised when an enabled edge is pending.

---
 rtl/gpio_mmio.sv | 87 ++++++++
 tb/tb_gpio_mmio.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/gpio_mmio.sv
// Purpose: memory-mapped GPIO with 2-flop input sync, per-bit debounce, sticky W1C rising-edge capture, output reg, level IRQ.
// Latency: reads return data the cycle after re_i; input change reaches DATA_IN DEB_CYCLES+1 edges after first sample.
// Backpressure: none; every bus access completes in one cycle, no wait states.
// Ports: clk_i/reset_i (sync, active-low) | addr_i, we_i, re_i, wdata_i, rdata_o: word-indexed register bus
//        GPIO_i: async inputs | GPIO_o: DATA_OUT flops | irq_o: |(EDGE & IRQ_EN)
// Map: 0 DATA_IN (RO), 1 DATA_OUT (RW), 2 EDGE (RO/W1C), 3 IRQ_EN (RW); unused upper bits read 0.
module gpio_mmio #(
  parameter int DEB_CYCLES = 4,
  parameter int WIDTH      = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [1:0]       addr_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  input  logic [WIDTH-1:0] GPIO_i,
  output logic [WIDTH-1:0] GPIO_o,
  output logic             irq_o
);

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] sync1, sync2, deb, deb_nxt, rise;
  logic [WIDTH-1:0] data_out, edge_reg, edge_nxt, irq_en, w1c_mask, rd_sel;
  logic [7:0]       cnt     [WIDTH];
  logic [7:0]       cnt_nxt [WIDTH];
  logic             unused_wdata;

  assign unused_wdata = ^wdata_i[31:WIDTH];

  // Debounce: a bit flips only after sync2 has disagreed with deb for
  // DEB_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    deb_nxt = deb;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = 8'd0;
      if (sync2[i] != deb[i]) begin
        if (cnt[i] == DEB_LAST) deb_nxt[i] = sync2[i];
        else                    cnt_nxt[i] = cnt[i] + 8'd1;
      end
    end
  end

  assign rise     = deb_nxt & ~deb;
  assign w1c_mask = (we_i && addr_i == 2'd2) ? wdata_i[WIDTH-1:0] : '0;
  // A rising edge on the same cycle as its clear must not be lost.
  assign edge_nxt = (edge_reg & ~w1c_mask) | rise;

  always_comb begin
    rd_sel = '0;
    case (addr_i)
      2'd0:    rd_sel = deb;
      2'd1:    rd_sel = data_out;
      2'd2:    rd_sel = edge_reg;
      default: rd_sel = irq_en;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      data_out <= '0;
      edge_reg <= '0;
      irq_en   <= '0;
      rdata_o  <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= 8'd0;
    end else begin
      sync1    <= GPIO_i;
      sync2    <= sync1;
      deb      <= deb_nxt;
      edge_reg <= edge_nxt;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
      if (we_i && addr_i == 2'd1) data_out <= wdata_i[WIDTH-1:0];
      if (we_i && addr_i == 2'd3) irq_en   <= wdata_i[WIDTH-1:0];
      // rd_sel sees pre-edge state, so a read racing a write returns the old value.
      rdata_o  <= re_i ? 32'(rd_sel) : 32'd0;
    end
  end

  assign GPIO_o = data_out;
  assign irq_o  = |(edge_reg & irq_en);

endmodule

// File: tb/tb_gpio_mmio.sv
// Purpose: directed self-checking bench for gpio_mmio (DEB_CYCLES=4, WIDTH=8).
// Latency: inputs driven 1ns after posedge, outputs sampled 1ns after posedge.
// Backpressure: n/a; fixed-length stimulus, always terminates.
module tb_gpio_mmio;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic [1:0]  addr_i = 2'd0;
  logic        we_i = 1'b0;
  logic        re_i = 1'b0;
  logic [31:0] wdata_i = 32'd0;
  logic [31:0] rdata_o;
  logic [7:0]  GPIO_i = 8'h00;
  logic [7:0]  GPIO_o;
  logic        irq_o;

  int vectors = 0;
  int miscompares = 0;

  gpio_mmio #(.DEB_CYCLES(4), .WIDTH(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .addr_i(addr_i), .we_i(we_i), .re_i(re_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .GPIO_i(GPIO_i), .GPIO_o(GPIO_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [1:0] a, input logic [31:0] d);
    we_i = w; re_i = r; addr_i = a; wdata_i = d;
  endtask

  task automatic idle();
    we_i = 1'b0; re_i = 1'b0; wdata_i = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a);
    drive(1'b0, 1'b1, a, 32'd0);
    cyc();
    idle();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    drive(1'b1, 1'b0, a, d);
    cyc();
    idle();
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    GPIO_i  = 8'h03;
    drive(1'b1, 1'b1, 2'd1, 32'hFF);   // write during reset must lose
    for (int c = 0; c < 3; c++) begin
      cyc();
      vectors++; if (GPIO_o !== 8'h00) begin miscompares++; $display("FAIL reset_gpio_o c%0d got %h exp 00", c, GPIO_o); end
      vectors++; if (rdata_o !== 32'd0) begin miscompares++; $display("FAIL reset_rdata c%0d got %h exp 0", c, rdata_o); end
      vectors++; if (irq_o !== 1'b0) begin miscompares++; $display("FAIL reset_irq c%0d got %b exp 0", c, irq_o); end
      vectors++; if (dut.deb !== 8'h00) begin miscompares++; $display("FAIL reset_deb c%0d got %h exp 00", c, dut.deb); end
    end
    idle();
  endtask

  task automatic test_debounce_latency();
    // Next edge (k) is the first post-reset sample of GPIO_i=03.
    reset_i = 1'b1;
    drive(1'b1, 1'b0, 2'd3, 32'h03);
    for (int j = 0; j < 5; j++) begin
      cyc();
      idle();
      vectors++; if (irq_o !== 1'b0) begin miscompares++; $display("FAIL latency_early edge k+%0d irq got %b exp 0", j, irq_o); end
    end
    rd(2'd0);   // edge k+5: deb and EDGE update here
    vectors++; if (irq_o !== 1'b1) begin miscompares++; $display("FAIL latency_k5_irq got %b exp 1", irq_o); end
    vectors++; if (rdata_o !== 32'd0) begin miscompares++; $display("FAIL latency_k5_prev_data_in got %h exp 0", rdata_o); end
    rd(2'd0);
    vectors++; if (rdata_o !== 32'h03) begin miscompares++; $display("FAIL latency_data_in got %h exp 3", rdata_o); end
    rd(2'd2);
    vectors++; if (rdata_o !== 32'h03) begin miscompares++; $display("FAIL latency_edge got %h exp 3", rdata_o); end
  endtask

  task automatic test_glitch();
    GPIO_i = 8'h07;
    repeat (3) cyc();
    GPIO_i = 8'h03;
    repeat (12) cyc();
    rd(2'd0);
    vectors++; if (rdata_o !== 32'h03) begin miscompares++; $display("FAIL glitch3_data_in got %h exp 3", rdata_o); end
    rd(2'd2);
    vectors++; if (rdata_o !== 32'h03) begin miscompares++; $display("FAIL glitch3_edge got %h exp 3", rdata_o); end
    GPIO_i = 8'h07;
    repeat (4) cyc();
    GPIO_i = 8'h03;
    repeat (12) cyc();
    rd(2'd2);
    vectors++; if (rdata_o !== 32'h07) begin miscompares++; $display("FAIL pulse4_edge got %h exp 7", rdata_o); end
    rd(2'd0);
    vectors++; if (rdata_o !== 32'h03) begin miscompares++; $display("FAIL pulse4_settled_data_in got %h exp 3", rdata_o); end
    wr(2'd2, 32'h04);
    rd(2'd2);
    vectors++; if (rdata_o !== 32'h03) begin miscompares++; $display("FAIL w1c_bit2 got %h exp 3", rdata_o); end
    wr(2'd0, 32'hFF);
    rd(2'd0);
    vectors++; if (rdata_o !== 32'h03) begin miscompares++; $display("FAIL data_in_write_ignored got %h exp 3", rdata_o); end
  endtask

  task automatic test_output();
    wr(2'd1, 32'hFFFF_FF5A);
    vectors++; if (GPIO_o !== 8'h5A) begin miscompares++; $display("FAIL out_gpio got %h exp 5a", GPIO_o); end
    rd(2'd1);
    vectors++; if (rdata_o !== 32'h0000_005A) begin miscompares++; $display("FAIL out_readback got %h exp 5a", rdata_o); end
    drive(1'b1, 1'b1, 2'd1, 32'h33);
    cyc();
    idle();
    vectors++; if (rdata_o !== 32'h5A) begin miscompares++; $display("FAIL rw_same_old got %h exp 5a", rdata_o); end
    vectors++; if (GPIO_o !== 8'h33) begin miscompares++; $display("FAIL rw_same_gpio got %h exp 33", GPIO_o); end
    cyc();
    vectors++; if (rdata_o !== 32'd0) begin miscompares++; $display("FAIL no_read_zero got %h exp 0", rdata_o); end
  endtask

  task automatic test_irq_w1c();
    wr(2'd3, 32'h01);
    vectors++; if (irq_o !== 1'b1) begin miscompares++; $display("FAIL irq_set got %b exp 1", irq_o); end
    drive(1'b1, 1'b1, 2'd2, 32'h01);
    cyc();
    idle();
    vectors++; if (rdata_o !== 32'h03) begin miscompares++; $display("FAIL w1c_read_old got %h exp 3", rdata_o); end
    vectors++; if (irq_o !== 1'b0) begin miscompares++; $display("FAIL w1c_irq_clear got %b exp 0", irq_o); end
    rd(2'd2);
    vectors++; if (rdata_o !== 32'h02) begin miscompares++; $display("FAIL w1c_edge got %h exp 2", rdata_o); end
    GPIO_i = 8'h02;
    repeat (12) cyc();
    GPIO_i = 8'h03;
    repeat (5) cyc();
    vectors++; if (irq_o !== 1'b0) begin miscompares++; $display("FAIL coincide_pre got %b exp 0", irq_o); end
    wr(2'd2, 32'h01);   // clear lands on the same edge bit 0 rises
    vectors++; if (irq_o !== 1'b1) begin miscompares++; $display("FAIL coincide_irq got %b exp 1", irq_o); end
    rd(2'd2);
    vectors++; if (rdata_o !== 32'h03) begin miscompares++; $display("FAIL coincide_edge got %h exp 3", rdata_o); end
  endtask

  task automatic test_reset_mid();
    GPIO_i = 8'h00;
    repeat (12) cyc();
    wr(2'd1, 32'hA5);
    GPIO_i = 8'h01;
    repeat (4) cyc();
    reset_i = 1'b0;
    cyc();
    vectors++; if (GPIO_o !== 8'h00) begin miscompares++; $display("FAIL mid_reset_gpio got %h exp 00", GPIO_o); end
    vectors++; if (irq_o !== 1'b0) begin miscompares++; $display("FAIL mid_reset_irq got %b exp 0", irq_o); end
    vectors++; if (dut.cnt[0] !== 8'd0) begin miscompares++; $display("FAIL mid_reset_cnt got %0d exp 0", dut.cnt[0]); end
    vectors++; if (dut.deb !== 8'h00) begin miscompares++; $display("FAIL mid_reset_deb got %h exp 00", dut.deb); end
    cyc();
    reset_i = 1'b1;
    drive(1'b1, 1'b0, 2'd3, 32'h01);
    for (int j = 0; j < 5; j++) begin
      cyc();
      idle();
      vectors++; if (irq_o !== 1'b0) begin miscompares++; $display("FAIL post_reset_early k+%0d got %b exp 0", j, irq_o); end
    end
    cyc();
    vectors++; if (irq_o !== 1'b1) begin miscompares++; $display("FAIL post_reset_k5_irq got %b exp 1", irq_o); end
    rd(2'd2);
    vectors++; if (rdata_o !== 32'h01) begin miscompares++; $display("FAIL post_reset_edge got %h exp 1", rdata_o); end
    rd(2'd0);
    vectors++; if (rdata_o !== 32'h01) begin miscompares++; $display("FAIL post_reset_data_in got %h exp 1", rdata_o); end
  endtask

  initial begin
    test_reset();
    test_debounce_latency();
    test_glitch();
    test_output();
    test_irq_w1c();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
